// File: rtl/rv_m_pkg.sv
// rtl/rv_m_pkg.sv - shared RV32M/RV64M func3 codes, FSM encoding and decode helpers
package rv_m_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_SPEC = 2'd3
    } state_t;

    // DIV/DIVU/REM/REMU all have func3[2] set
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // REM/REMU return the remainder rather than the quotient
    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    // op_a is signed for MULH, MULHSU, DIV and REM
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // op_b is signed for MULH, DIV and REM (MULHSU keeps it unsigned)
    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - two-lane conditional two's-complement negation
module muldiv_sign_fix #(
    parameter int WA = 32,
    parameter int WB = 32
) (
    input  logic [WA-1:0] i_a,
    input  logic          i_neg_a,
    input  logic [WB-1:0] i_b,
    input  logic          i_neg_b,
    output logic [WA-1:0] o_a,
    output logic [WB-1:0] o_b
);

    // Used for magnitudes on entry and for sign restoration on exit
    assign o_a = i_neg_a ? -i_a : i_a;
    assign o_b = i_neg_b ? -i_b : i_b;

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative shift-add multiply / restoring divide for the EX stage
module ex_muldiv_unit
    import rv_m_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam int AW = 2 * XLEN;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_func3;
    logic            r_neg;
    logic [XLEN-1:0] r_opd;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_load;
    logic            w_step;
    logic            w_finish;

    logic            w_sa;
    logic            w_sb;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic            w_take_spec;
    logic            w_res_neg;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN-1:0] w_spec_val;

    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_trial;
    logic [AW-1:0]   w_mul_next;
    logic [AW-1:0]   w_div_next;

    logic [XLEN-1:0] w_div_sel;
    logic [AW-1:0]   w_prod_fix;
    logic [XLEN-1:0] w_div_fix;
    logic [XLEN-1:0] w_fix_result;

    // Entry decode: operand signs and the RISC-V special cases
    assign w_sa        = is_signed_a(func3) & op_a[XLEN-1];
    assign w_sb        = is_signed_b(func3) & op_b[XLEN-1];
    assign w_b_zero    = (op_b == '0);
    assign w_ovf       = is_div(func3) && is_signed_a(func3)
                         && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign w_special   = is_div(func3) & (w_b_zero | w_ovf);
    assign w_take_spec = (EARLY_OUT != 0) && w_special;
    assign w_spec_val  = is_rem(func3) ? (w_b_zero ? op_a : '0)
                                       : (w_b_zero ? '1   : op_a);

    // Quotient sign is cleared for b=0 so the iterative path also yields all ones
    assign w_res_neg = is_div(func3)
                       ? (is_rem(func3) ? w_sa : ((w_sa ^ w_sb) & ~w_b_zero))
                       : (w_sa ^ w_sb);

    muldiv_sign_fix #(.WA(XLEN), .WB(XLEN)) u_entry_fix (
        .i_a     (op_a),
        .i_neg_a (w_sa),
        .i_b     (op_b),
        .i_neg_b (w_sb),
        .o_a     (w_mag_a),
        .o_b     (w_mag_b)
    );

    // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right
    assign w_mul_sum  = {1'b0, r_acc[AW-1:XLEN]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide step: trial-subtract the divisor from the shifted partial remainder
    assign w_div_trial = r_acc[AW-1:XLEN-1] - {1'b0, r_opd};
    assign w_div_next  = w_div_trial[XLEN] ? {r_acc[AW-2:0], 1'b0}
                                           : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // Exit: restore sign on the full product or on the selected quotient/remainder
    assign w_div_sel = is_rem(r_func3) ? r_acc[AW-1:XLEN] : r_acc[XLEN-1:0];

    muldiv_sign_fix #(.WA(AW), .WB(XLEN)) u_exit_fix (
        .i_a     (r_acc),
        .i_neg_a (r_neg),
        .i_b     (w_div_sel),
        .i_neg_b (r_neg),
        .o_a     (w_prod_fix),
        .o_b     (w_div_fix)
    );

    assign w_fix_result = is_div(r_func3)      ? w_div_fix
                        : (r_func3 == F3_MUL)  ? w_prod_fix[XLEN-1:0]
                                               : w_prod_fix[AW-1:XLEN];

    // Next-state and control strobes; flush always wins and suppresses done
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !flush) begin
                    w_load = 1'b1;
                    w_next = w_take_spec ? ST_SPEC : ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    w_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == '0) begin
                        w_next = ST_FIX;
                    end
                end
            end
            ST_FIX, ST_SPEC: begin
                w_next   = ST_IDLE;
                w_finish = !flush;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand latch, iteration datapath and registered result/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_func3  <= '0;
            r_neg    <= 1'b0;
            r_opd    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_result <= (r_state == ST_SPEC) ? r_acc[XLEN-1:0] : w_fix_result;
            end
            if (w_load) begin
                r_func3 <= func3;
                r_neg   <= w_res_neg;
                r_opd   <= is_div(func3) ? w_mag_b : w_mag_a;
                r_cnt   <= CW'(XLEN - 1);
                if (w_take_spec) begin
                    r_acc <= {{XLEN{1'b0}}, w_spec_val};
                end else begin
                    r_acc <= {{XLEN{1'b0}}, (is_div(func3) ? w_mag_a : w_mag_b)};
                end
            end else if (w_step) begin
                r_acc <= is_div(r_func3) ? w_div_next : w_mul_next;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule
